sram_arb_init_2p: RTL

- Shares one single-port 1024x32 SRAM macro (bit-masked write, registered read) between two requesters, e.g. fetch (port 0) and data (port 1).
- After reset, zero-fills the whole array, then runs round-robin arbitration with valid/ready request handshakes.
- Routes read data back to the issuing port one cycle after acceptance.
- Sits between core-side memory ports and the SRAM macro instance.

---
 rtl/sram_arb_init_2p.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sram_arb_init_2p.sv
// sram_arb_init_2p: shares one single-port SRAM macro between two requesters.
// After reset the whole array is filled with INIT_VALUE. The block then
// arbitrates round-robin between port 0 and port 1. Accepted reads return
// on the issuing port one cycle later.
// Optional build macro SRAM_ARB_PERF_EN adds saturating per-port stall counters.
module sram_arb_init_2p #(
  parameter int unsigned     BITS       = 32,
  parameter int unsigned     WORD_DEPTH = 1024,
  parameter int unsigned     ADDR_WIDTH = 10,
  parameter logic [BITS-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic                  p0_req_we,
  input  logic [BITS-1:0]       p0_req_wdata,
  input  logic [BITS-1:0]       p0_req_wmask,
  output logic                  p0_rsp_valid,
  output logic [BITS-1:0]       p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic                  p1_req_we,
  input  logic [BITS-1:0]       p1_req_wdata,
  input  logic [BITS-1:0]       p1_req_wmask,
  output logic                  p1_rsp_valid,
  output logic [BITS-1:0]       p1_rsp_rdata,
  output logic                  init_done,
`ifdef SRAM_ARB_PERF_EN
  output logic [15:0]           p0_stall_cnt,
  output logic [15:0]           p1_stall_cnt,
`endif
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;      // 0 = port 0 granted last, 1 = port 1
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_port_q, rd_port_d;
  logic [BITS-1:0]       rdata0_q, rdata1_q;
  logic                  gnt0, gnt1;

  // Next-state, grant and SRAM drive; everything is held at zero while reset is high
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rd_pend_d  = 1'b0;
    rd_port_d  = rd_port_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wd    = '0;
    sram_wmask = '0;
    if (!reset) begin
      unique case (state_q)
        ST_INIT: begin
          sram_ce    = 1'b1;
          sram_we    = 1'b1;
          sram_wmask = '1;
          sram_wd    = INIT_VALUE;
          sram_addr  = cnt_q;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = ST_RUN;
        end
        ST_RUN: begin
          gnt0 = p0_req_valid && (!p1_req_valid || last_q);
          gnt1 = p1_req_valid && (!p0_req_valid || !last_q);
          if (gnt0) begin
            sram_ce    = 1'b1;
            sram_we    = p0_req_we;
            sram_addr  = p0_req_addr;
            sram_wd    = p0_req_wdata;
            sram_wmask = p0_req_we ? p0_req_wmask : '0;
            last_d     = 1'b0;
            rd_pend_d  = !p0_req_we;
            rd_port_d  = 1'b0;
          end else if (gnt1) begin
            sram_ce    = 1'b1;
            sram_we    = p1_req_we;
            sram_addr  = p1_req_addr;
            sram_wd    = p1_req_wdata;
            sram_wmask = p1_req_we ? p1_req_wmask : '0;
            last_d     = 1'b1;
            rd_pend_d  = !p1_req_we;
            rd_port_d  = 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign init_done    = !reset && (state_q == ST_RUN);
  assign p0_rsp_valid = !reset && rd_pend_q && !rd_port_q;
  assign p1_rsp_valid = !reset && rd_pend_q && rd_port_q;
  assign p0_rsp_rdata = p0_rsp_valid ? sram_rd : rdata0_q;
  assign p1_rsp_rdata = p1_rsp_valid ? sram_rd : rdata1_q;

  // State, init counter, round-robin pointer, read tracking and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
      if (p0_rsp_valid) rdata0_q <= sram_rd;
      if (p1_rsp_valid) rdata1_q <= sram_rd;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  // Saturating counts of RUN cycles where a port is valid but not granted
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_stall_cnt <= '0;
      p1_stall_cnt <= '0;
    end else if (state_q == ST_RUN) begin
      if (p0_req_valid && !gnt0 && (p0_stall_cnt != '1)) p0_stall_cnt <= p0_stall_cnt + 16'd1;
      if (p1_req_valid && !gnt1 && (p1_stall_cnt != '1)) p1_stall_cnt <= p1_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
